// File: rtl/run_controller_pkg.sv
// Shared types and default sizes for the run controller block.
package run_ctrl_pkg;

  localparam int              RC_AW          = 8;
  localparam int              RC_DW          = 8;
  localparam int              RC_CW          = 16;
  localparam int              RC_INIT_CYCLES = 2;
  localparam logic [15:0]     RC_TIMEOUT     = 16'hFFFF;

  // Sequencer states. Encoding is fixed so debug traces stay comparable.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BOOT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } run_state_t;

endpackage

// File: rtl/run_controller_if.sv
// Host, core and data-memory signal bundle for the run controller.
// Handshake: a host access happens in exactly the cycle host_req is high
// and host_gnt comes back high; reads are combinational (host_rdata is valid
// in that same cycle), writes commit on the next clock edge. An ungranted
// request is simply dropped; the host must hold host_req to retry.
interface run_controller_if
  import run_ctrl_pkg::*;
#(
  parameter int AW = RC_AW,
  parameter int DW = RC_DW
);

  // host side
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic [DW-1:0] host_rdata;

  // core side
  logic          core_ack;
  logic [AW-1:0] core_addr;
  logic          core_re;
  logic          core_we;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;

  // data memory side
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Controller view.
  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata,
    input  core_ack, core_addr, core_re, core_we, core_wdata,
    output core_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rdata
  );

  // Environment view (host, core and memory together).
  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata,
    output core_ack, core_addr, core_re, core_we, core_wdata,
    input  core_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/run_controller_cycle_counter.sv
// Saturating execution-cycle counter with synchronous clear.
module run_cycle_counter
  import run_ctrl_pkg::*;
#(
  parameter int CW = RC_CW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear_i,
  input  logic          enable_i,
  input  logic [CW-1:0] limit_i,
  output logic [CW-1:0] count_o,
  output logic          at_limit_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW:0]   count_inc;

  // at_limit means the count equals the limit once this cycle is counted,
  // so the owner can react in the same cycle the limit is reached.
  assign count_inc  = {1'b0, count_q} + {{CW{1'b0}}, 1'b1};
  assign at_limit_o = (count_q == limit_i) || (count_inc == {1'b0, limit_i});
  assign count_o    = count_q;

  // Next count: clear wins, otherwise step until the limit is held.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != limit_i)) begin
      count_d = count_inc[CW-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Run sequencer and data-memory arbiter around the single-cycle core:
// holds the core in init while the host owns memory, boots it, counts its
// run cycles, and stops on the core's done flag or a cycle-limit timeout.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int          AW          = RC_AW,
  parameter int          DW          = RC_DW,
  parameter int          CW          = RC_CW,
  parameter int          INIT_CYCLES = RC_INIT_CYCLES,
  parameter logic [CW-1:0] TIMEOUT   = CW'(RC_TIMEOUT)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  output logic            core_init,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [CW-1:0]   cycles,
  output run_state_t      state_dbg,
  run_controller_if.slave bus
);

  localparam int BW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(INIT_CYCLES - 1);

  run_state_t    state_q, state_d;
  logic [BW-1:0] boot_cnt_q, boot_cnt_d;
  logic          timeout_q, timeout_d;
  logic          cnt_clear;
  logic          cnt_enable;
  logic          cnt_at_limit;
  logic          host_owns;
  logic          core_owns;

  run_cycle_counter #(
    .CW (CW)
  ) u_cycle_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (cnt_clear),
    .enable_i   (cnt_enable),
    .limit_i    (TIMEOUT),
    .count_o    (cycles),
    .at_limit_o (cnt_at_limit)
  );

  // Every RUN cycle is counted, including the one where ack or abort lands.
  assign cnt_enable = (state_q == ST_RUN);

  // Sequencer next-state: start/rerun, boot timing, completion, abort.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    timeout_d  = timeout_q;
    cnt_clear  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_BOOT;
          boot_cnt_d = '0;
          timeout_d  = 1'b0;
          cnt_clear  = 1'b1;
        end
      end
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = ST_RUN;
          boot_cnt_d = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // The done flag beats the limit when both land in one cycle.
        if (bus.core_ack) begin
          state_d   = ST_DONE;
          timeout_d = 1'b0;
        end else if (cnt_at_limit) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Abort overrides everything; results of the last run are kept.
    if (abort) begin
      state_d    = ST_IDLE;
      boot_cnt_d = '0;
      timeout_d  = timeout_q;
      cnt_clear  = 1'b0;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      boot_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign core_init = (state_q != ST_RUN);
  assign busy      = (state_q == ST_BOOT) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

  // Grant depends only on the current state, so a start in the same cycle
  // still lets that cycle's host access complete.
  assign host_owns = bus.host_req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign core_owns = (state_q == ST_RUN);

  // Memory port mux: host in IDLE/DONE, core in RUN, quiet otherwise.
  always_comb begin
    bus.mem_addr   = {AW{1'b0}};
    bus.mem_wdata  = {DW{1'b0}};
    bus.mem_we     = 1'b0;
    bus.mem_re     = 1'b0;
    bus.host_gnt   = host_owns;
    bus.host_rdata = {DW{1'b0}};
    bus.core_rdata = {DW{1'b0}};
    if (host_owns) begin
      bus.mem_addr   = bus.host_addr;
      bus.mem_wdata  = bus.host_wdata;
      bus.mem_we     = bus.host_we;
      bus.mem_re     = !bus.host_we;
      bus.host_rdata = bus.mem_rdata;
    end else if (core_owns) begin
      bus.mem_addr   = bus.core_addr;
      bus.mem_wdata  = bus.core_wdata;
      bus.mem_we     = bus.core_we;
      bus.mem_re     = bus.core_re;
      bus.core_rdata = bus.mem_rdata;
    end
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
Sequencer and data-memory arbiter wrapped around the single-cycle processor top level.
- Holds the core in init while a host loads or inspects data memory.
- Releases the core to run, counts execution cycles, and detects completion through the core's done flag, with a timeout as backstop.
- Multiplexes the single data_mem port between host and core so they never contend.

Parameters:
AW, 8, data memory address width
DW, 8, data memory word width
CW, 16, cycle counter width
INIT_CYCLES, 2, cycles core_init stays high in BOOT (min 1)
TIMEOUT, 16'hFFFF, RUN cycle limit before forced DONE (must fit CW)

Ports:
clk  in  1  clock, posedge
reset_n  in  1  asynchronous active-low reset
start  in  1  level-sampled run request
abort  in  1  return to IDLE from any state
host_req  in  1  host memory access request
host_we  in  1  host write enable (valid with host_req)
host_addr  in  AW  host address
host_wdata  in  DW  host write data
host_gnt  out  1  host access granted this cycle
host_rdata  out  DW  host read data
core_init  out  1  drives processor init/reset (active high)
core_ack  in  1  processor done flag
core_addr  in  AW  core data address
core_re  in  1  core read enable
core_we  in  1  core write enable
core_wdata  in  DW  core write data
core_rdata  out  DW  core read data
mem_addr  out  AW  to data_mem
mem_re  out  1  to data_mem
mem_we  out  1  to data_mem
mem_wdata  out  DW  to data_mem
mem_rdata  in  DW  from data_mem (combinational read)
busy  out  1  state is BOOT or RUN
done  out  1  state is DONE
timeout  out  1  last run ended by timeout (sticky)
cycles  out  CW  RUN cycle count

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, core_init=1, cycles=0, timeout=0, busy=0, done=0.
  - Boot counter=0.
- States: IDLE, BOOT, RUN, DONE. All state is registered; port muxing is combinational from state.
- IDLE:
  - core_init=1; host owns the memory.
  - start=1 -> BOOT; clear cycles, timeout and boot counter.
- BOOT:
  - core_init=1; neither side gets memory (mem_we=0, mem_re=0).
  - core_ack ignored.
  - Leave after exactly INIT_CYCLES cycles -> RUN.
- RUN:
  - core_init=0; core owns the memory.
  - cycles increments each RUN cycle and saturates at TIMEOUT.
  - core_ack=1 -> DONE with timeout=0.
  - Otherwise, cycles==TIMEOUT -> DONE with timeout=1.
  - If ack and the limit coincide in one cycle, ack wins (timeout=0).
  - The cycle on which ack is sampled is counted.
- DONE:
  - core_init=1 (freezes the core; its memory writes are blocked); host owns the memory.
  - cycles and timeout hold.
  - start=1 -> BOOT (rerun, same clears as from IDLE).
- abort=1: any state -> IDLE next edge; cycles and timeout hold. abort has priority over start.
- start while in BOOT or RUN: ignored.
- Host grant: host_gnt = host_req && state in {IDLE, DONE}.
  - When granted: mem_addr=host_addr, mem_we=host_we, mem_re=!host_we, mem_wdata=host_wdata, host_rdata=mem_rdata.
  - Zero-latency read, same cycle.
  - Ungranted requests are dropped, not queued.
- Start and host_req together in IDLE: the host access in that cycle completes (grant depends on current state); from BOOT onward host_gnt=0.
- Core port in RUN: mem_* = core_*, core_rdata=mem_rdata.
- Outside RUN: core_rdata=0, core_we/core_re ignored.
- Idle memory port: when no side owns the port, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
- Ungranted host: host_rdata=0.

Decomposition:
- Package run_ctrl_pkg:
  - state enum typedef (IDLE=2'd0, BOOT=2'd1, RUN=2'd2, DONE=2'd3).
  - Default-width localparams.
- One sub-module, run_cycle_counter: saturating CW-bit counter with clear, enable, limit input and at_limit output.
- Port muxing stays inline.

Test Plan:
1. reset_n=0 pulsed mid-RUN (cycles=12) -> same instant: state IDLE, core_init=1, cycles=0, busy=0, mem_we=0.
2. IDLE: host write 0x10<=0xA5, then read 0x10 -> host_gnt=1 both cycles, host_rdata=0xA5.
3. start for 1 cycle, core_ack raised on the 37th RUN cycle -> core_init=1 for 2 cycles, then 0; done=1, cycles=37, timeout=0, core_init=1 in DONE.
4. TIMEOUT=20, core_ack never asserted -> DONE after 20 RUN cycles, timeout=1, cycles=20; ack and limit coincident on cycle 20 -> timeout=0.
5. RUN with host_req=1, host_we=1 -> host_gnt=0, mem follows core_addr/core_we; DONE with core_we=1 -> mem_we=0.
6. abort at RUN cycle 5 -> IDLE next edge, core_init=1, cycles=5; start asserted during RUN -> no state change.
